// File: rtl/calc_port_responder.sv
// calc1 single-port command responder: add/sub/shift with fixed response latency.
// Operand 1 arrives with the command, operand 2 on the following cycle.
module calc_port_responder #(
    parameter int LATENCY = 1
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  req_cmd_in,
    input  logic [0:31] req_data_in,
    output logic [0:1]  out_resp,
    output logic [0:31] out_data,
    output logic        busy,
    output logic        cmd_dropped
);

    typedef enum logic [1:0] {IDLE, OPND2, WAIT, RESP} state_t;

    localparam bit         DIRECT   = (LATENCY == 1);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state, state_nx;
    logic [3:0]  cmd_q, cmd_nx;
    logic [31:0] op1_q, op1_nx;
    logic [1:0]  res_resp_q, res_resp_nx;
    logic [31:0] res_data_q, res_data_nx;
    logic [3:0]  cnt_q, cnt_nx;
    logic [1:0]  resp_q, resp_nx;
    logic [31:0] data_q, data_nx;
    logic        drop_q, drop_nx;

    logic [3:0]  cmd;
    logic [31:0] din;
    logic [32:0] sum;
    logic [4:0]  shamt;
    logic [1:0]  calc_resp;
    logic [31:0] calc_data;

    assign cmd = req_cmd_in;
    assign din = req_data_in;

    // Result datapath: operand 2 is taken straight from the bus in OPND2.
    always_comb begin
        sum       = {1'b0, op1_q} + {1'b0, din};
        shamt     = din[4:0];
        calc_resp = 2'd3;
        calc_data = '0;
        case (cmd_q)
            4'd1: begin
                if (sum[32]) begin
                    calc_resp = 2'd2;
                end else begin
                    calc_resp = 2'd1;
                    calc_data = sum[31:0];
                end
            end
            4'd2: begin
                if (din > op1_q) begin
                    calc_resp = 2'd2;
                end else begin
                    calc_resp = 2'd1;
                    calc_data = op1_q - din;
                end
            end
            4'd5: begin
                calc_resp = 2'd1;
                calc_data = op1_q << shamt;
            end
            4'd6: begin
                calc_resp = 2'd1;
                calc_data = op1_q >> shamt;
            end
            default: begin
                calc_resp = 2'd3;
                calc_data = '0;
            end
        endcase
    end

    always_comb begin
        state_nx    = state;
        cmd_nx      = cmd_q;
        op1_nx      = op1_q;
        res_resp_nx = res_resp_q;
        res_data_nx = res_data_q;
        cnt_nx      = cnt_q;
        resp_nx     = resp_q;
        data_nx     = data_q;
        drop_nx     = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd != 4'd0) begin
                    cmd_nx   = cmd;
                    op1_nx   = din;
                    state_nx = OPND2;
                end
            end
            OPND2: begin
                res_resp_nx = calc_resp;
                res_data_nx = calc_data;
                if (DIRECT) begin
                    resp_nx  = calc_resp;
                    data_nx  = calc_data;
                    state_nx = RESP;
                end else begin
                    cnt_nx   = CNT_INIT;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                drop_nx = (cmd != 4'd0);
                if (cnt_q <= 4'd1) begin
                    resp_nx  = res_resp_q;
                    data_nx  = res_data_q;
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt_q - 4'd1;
                end
            end
            RESP: begin
                resp_nx = 2'd0;
                data_nx = '0;
                if (cmd != 4'd0) begin
                    cmd_nx   = cmd;
                    op1_nx   = din;
                    state_nx = OPND2;
                end else begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cmd_q      <= '0;
            op1_q      <= '0;
            res_resp_q <= '0;
            res_data_q <= '0;
            cnt_q      <= '0;
            resp_q     <= '0;
            data_q     <= '0;
            drop_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            cmd_q      <= cmd_nx;
            op1_q      <= op1_nx;
            res_resp_q <= res_resp_nx;
            res_data_q <= res_data_nx;
            cnt_q      <= cnt_nx;
            resp_q     <= resp_nx;
            data_q     <= data_nx;
            drop_q     <= drop_nx;
        end
    end

    assign busy        = (state != IDLE);
    assign out_resp    = resp_q;
    assign out_data    = data_q;
    assign cmd_dropped = drop_q;

endmodule

// File: tb/tb_calc_port_responder.sv
// Scoreboard bench for calc_port_responder: one instance at latency 1, one at 4.
// Expected responses carry the cycle on which they must appear.
module tb_calc_port_responder;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        c_clk;
    logic        reset;
    logic [0:3]  cmd1, cmd4;
    logic [0:31] din1, din4;
    logic [0:1]  resp1, resp4;
    logic [0:31] dout1, dout4;
    logic        busy1, busy4;
    logic        drop1, drop4;

    exp_t q1[$];
    exp_t q4[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    calc_port_responder #(.LATENCY(1)) u1 (
        .c_clk(c_clk), .reset(reset),
        .req_cmd_in(cmd1), .req_data_in(din1),
        .out_resp(resp1), .out_data(dout1),
        .busy(busy1), .cmd_dropped(drop1)
    );

    calc_port_responder #(.LATENCY(4)) u4 (
        .c_clk(c_clk), .reset(reset),
        .req_cmd_in(cmd4), .req_data_in(din4),
        .out_resp(resp4), .out_data(dout4),
        .busy(busy4), .cmd_dropped(drop4)
    );

    initial begin
        c_clk = 1'b0;
        forever #5 c_clk = ~c_clk;
    end

    always @(posedge c_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: pops the scoreboard and flags spurious or late responses.
    always @(negedge c_clk) begin
        if (!reset) begin
            if (resp1 != 2'd0) begin
                if (q1.size() == 0) begin
                    chk("u1_spurious", 32'(resp1), 32'd0);
                end else begin
                    chk("u1_resp", 32'(resp1), 32'(q1[0].resp));
                    chk("u1_data", dout1, q1[0].data);
                    chk("u1_cycle", cyc, q1[0].cyc);
                    void'(q1.pop_front());
                end
            end else if (q1.size() > 0 && cyc > q1[0].cyc) begin
                chk("u1_missing", cyc, q1[0].cyc);
                void'(q1.pop_front());
            end
            if (resp4 != 2'd0) begin
                if (q4.size() == 0) begin
                    chk("u4_spurious", 32'(resp4), 32'd0);
                end else begin
                    chk("u4_resp", 32'(resp4), 32'(q4[0].resp));
                    chk("u4_data", dout4, q4[0].data);
                    chk("u4_cycle", cyc, q4[0].cyc);
                    void'(q4.pop_front());
                end
            end else if (q4.size() > 0 && cyc > q4[0].cyc) begin
                chk("u4_missing", cyc, q4[0].cyc);
                void'(q4.pop_front());
            end
        end
    end

    // Called at a negedge; returns at the negedge after the operand-2 edge.
    task automatic send(input int d, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] er,
                        input logic [31:0] ed);
        exp_t e;
        e.resp = er;
        e.data = ed;
        e.cyc  = cyc + 1 + ((d == 1) ? 1 : 4);
        if (d == 1) begin
            q1.push_back(e);
            cmd1 = c;
            din1 = a;
        end else begin
            q4.push_back(e);
            cmd4 = c;
            din4 = a;
        end
        @(negedge c_clk);
        if (d == 1) begin
            cmd1 = 4'd0;
            din1 = b;
        end else begin
            cmd4 = 4'd0;
            din4 = b;
        end
        @(negedge c_clk);
    endtask

    initial begin
        reset = 1'b1;
        cmd1 = '0;
        din1 = '0;
        cmd4 = '0;
        din4 = '0;
        repeat (3) @(negedge c_clk);
        chk("rst_resp1", 32'(resp1), 32'd0);
        chk("rst_data1", dout1, 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_busy4", 32'(busy4), 32'd0);
        chk("rst_drop4", 32'(drop4), 32'd0);
        reset = 1'b0;
        @(negedge c_clk);

        send(1, 4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2'd1, 32'h0200_0000);
        @(negedge c_clk);
        chk("add_idle_resp", 32'(resp1), 32'd0);
        chk("add_idle_data", dout1, 32'd0);
        chk("add_idle_busy", 32'(busy1), 32'd0);

        send(1, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0);
        send(1, 4'd1, 32'h8000_0000, 32'h7FFF_FFFF, 2'd1, 32'hFFFF_FFFF);
        send(1, 4'd2, 32'd5, 32'd7, 2'd2, 32'h0);
        send(1, 4'd2, 32'd7, 32'd5, 2'd1, 32'd2);
        send(1, 4'd2, 32'd9, 32'd9, 2'd1, 32'd0);
        send(1, 4'd5, 32'h0000_0001, 32'h0000_0021, 2'd1, 32'h0000_0002);
        send(1, 4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'h0000_0001);
        send(1, 4'd5, 32'h1234_5678, 32'hFFFF_FFE0, 2'd1, 32'h1234_5678);
        send(1, 4'd6, 32'hF000_000F, 32'd4, 2'd1, 32'h0F00_0000);
        send(1, 4'd3, 32'h1111_1111, 32'h2222_2222, 2'd3, 32'h0);
        send(1, 4'd4, 32'h1, 32'h1, 2'd3, 32'h0);
        send(1, 4'd15, 32'hFFFF_FFFF, 32'h1, 2'd3, 32'h0);
        @(negedge c_clk);
        chk("u1_idle_busy", 32'(busy1), 32'd0);

        send(4, 4'd1, 32'd10, 32'd20, 2'd1, 32'd30);
        cmd4 = 4'd1;
        din4 = 32'hDEAD_BEEF;
        @(negedge c_clk);
        chk("drop_pulse", 32'(drop4), 32'd1);
        cmd4 = 4'd0;
        @(negedge c_clk);
        chk("drop_clear", 32'(drop4), 32'd0);
        chk("wait_busy", 32'(busy4), 32'd1);
        @(negedge c_clk);
        send(4, 4'd2, 32'd100, 32'd1, 2'd1, 32'd99);
        chk("b2b_busy", 32'(busy4), 32'd1);
        repeat (6) @(negedge c_clk);
        chk("u4_idle_busy", 32'(busy4), 32'd0);

        cmd1 = 4'd1;
        din1 = 32'd7;
        @(posedge c_clk);
        #2;
        chk("pre_rst_busy", 32'(busy1), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy1), 32'd0);
        chk("arst_resp", 32'(resp1), 32'd0);
        chk("arst_data", dout1, 32'd0);
        #1;
        reset = 1'b0;
        cmd1 = 4'd0;
        din1 = 32'd9;
        repeat (20) @(negedge c_clk);
        chk("post_rst_busy", 32'(busy1), 32'd0);
        send(1, 4'd1, 32'd2, 32'd3, 2'd1, 32'd5);

        repeat (8) @(negedge c_clk);
        chk("q1_drained", q1.size(), 32'd0);
        chk("q4_drained", q4.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
